trigger_frame_receiver: RTL and testbench
=========================================

# trigger_frame_receiver

Receive-side counterpart of the trigger frame transmitter. Sits after the 8b/10b decoder on the trigger fibre link. Consumes the decoded byte stream (data plus K-flag) and delineates the fixed 10-byte frame (SOP, status, control, address 0, 4 data bytes, CRC8, EOP). It validates framing and CRC, emits a one-cycle trigger pulse for valid trigger frames, latches frame fields, and keeps link-quality counters and a lock indication.

## Interface
- SOP, 8'h3C: start-of-packet K character.
- EOP, 8'hBC: end-of-packet K character.
- TRIG_MASK, 8'h08: control-byte bits that mark a trigger frame.
- LOCK_COUNT, 4: consecutive good frames required to assert `locked`.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte strobe from decoder; all other rx_* inputs are sampled only when high.
- rx_data  in  8  decoded byte.
- rx_is_k  in  1  byte is a K (control) character.
- rx_code_err  in  1  decoder code or disparity error on this byte.
- clr_counters  in  1  synchronous clear of both error counters.
- trigger_out  out  1  one-cycle pulse per valid trigger frame.
- frame_valid  out  1  one-cycle pulse per valid frame (idle or trigger).
- frame_status  out  8  status byte of the last valid frame.
- frame_ctrl  out  8  control byte (address 1) of the last valid frame.
- frame_addr0  out  8  address-0 byte of the last valid frame.
- frame_data  out  32  data bytes of the last valid frame; first received byte is bits [31:24].
- crc_err_count  out  16  saturating count of CRC failures.
- frame_err_count  out  16  saturating count of framing/code errors.
- locked  out  1  link lock indication.

## Operation
- FSM states: HUNT, PAYLOAD, EOP_WAIT. Byte index counter `idx` is 3 bits, 0..7, for the payload bytes.
- HUNT: on an accepted byte with K=1, data=SOP, and no code error: clear the CRC to 8'h00, set idx=0, go to PAYLOAD. All other bytes are ignored. Ignored bytes do not count as errors.
- PAYLOAD: each accepted byte is stored in shadow registers by idx: 0 status, 1 control, 2 addr0, 3..6 data, 7 CRC.
  - Bytes at idx 0..6 update the CRC. Byte at idx 7 is compared, not folded into the CRC.
  - Advance idx after each byte. After idx 7, go to EOP_WAIT.
- CRC8: polynomial x^8+x^2+x+1 (0x07), init 8'h00, MSB first, no reflection, no final XOR. Computed over the 7 bytes status through data[3].
- EOP_WAIT: on an accepted byte with K=1, data=EOP, and no code error:
  - If the CRC matches: copy the shadow registers to the frame_* outputs, pulse frame_valid, and pulse trigger_out if (ctrl & TRIG_MASK) != 0.
  - If the CRC does not match: increment crc_err_count; outputs are not updated.
  - In both cases, return to HUNT.
- Framing errors increment frame_err_count and return to HUNT. They are:
  - a code error in PAYLOAD or EOP_WAIT;
  - any K byte in PAYLOAD;
  - a non-EOP byte in EOP_WAIT.
- Resync: if the erroring byte is a clean SOP K character, count the error and go directly to PAYLOAD with idx=0 and CRC cleared. Do not pass through HUNT.
- Lock: a 3-bit counter of consecutive good frames.
  - Each good frame increments it, saturating at LOCK_COUNT. `locked` is high while counter == LOCK_COUNT.
  - Any CRC or framing error clears the counter and drops `locked` on the next cycle.
- Counters saturate at 16'hFFFF. If clr_counters and an increment occur in the same cycle, clear wins.
- A code error while in HUNT is not counted.

## Timing
- All outputs are registered.
- Reset values: trigger_out=0, frame_valid=0, frame_* = 0, both counters = 0, locked=0, state=HUNT, idx=0, CRC=0.
- Reset asserted mid-frame abandons the frame. No pulse is generated and no counter is incremented.
- trigger_out and frame_valid rise on the clock edge after the EOP byte is accepted. They last exactly one cycle. frame_* are updated on the same edge.
- rx_valid may be continuous or have gaps of any length. Gaps do not time out and do not change state.
- Minimum frame-to-frame spacing is 10 accepted bytes, so back-to-back frames are supported. Pulses from consecutive frames are at least 10 clocks apart.
- Counter and lock updates occur on the same edge as the frame result.

## Test plan
- Idle frame: 3C(K) 00 00 00 00 00 00 00 00 BC(K), continuous rx_valid -> frame_valid pulses one cycle after EOP; trigger_out stays 0; frame_ctrl=00.
- Trigger frame: 3C(K) 00 08 00 00 00 00 00 4F BC(K) -> trigger_out and frame_valid pulse together; frame_ctrl=08; frame_data=0.
- CRC error: trigger frame with CRC byte 4E -> no pulses; crc_err_count=1; frame_* unchanged.
- Truncation/resync: 3C(K) 00 08 followed by 3C(K) and then a full trigger frame -> frame_err_count=1; trigger_out pulses once, for the second frame.
- Lock: 4 good frames -> locked=1 after the 4th EOP; a code error in the 5th frame -> locked=0, frame_err_count=1; clr_counters -> both counters 0.
- Gapped input and reset: trigger frame with random rx_valid gaps -> same result as continuous input; reset asserted at idx 4 -> no pulse, counters 0, next clean frame decodes normally.

Source files
------------

// File: rtl/trigger_frame_receiver_if.sv
// Decoded byte stream from the 8b/10b decoder into the trigger frame receiver.
// The decoder side drives (master); the frame receiver samples (slave).
interface trigger_frame_receiver_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_is_k;
  logic       rx_code_err;

  modport master (output rx_valid, output rx_data, output rx_is_k, output rx_code_err);
  modport slave  (input  rx_valid, input  rx_data, input  rx_is_k, input  rx_code_err);
endinterface

// File: rtl/trigger_frame_receiver.sv
// Trigger frame receiver: delineates the 10-byte frame SOP/status/ctrl/addr0/
// data[4]/CRC8/EOP from the decoded byte stream, checks framing and CRC,
// pulses frame_valid/trigger_out for good frames, and keeps error counters
// plus a lock indication built from consecutive good frames.
module trigger_frame_receiver #(
  parameter logic [7:0] SOP        = 8'h3C,
  parameter logic [7:0] EOP        = 8'hBC,
  parameter logic [7:0] TRIG_MASK  = 8'h08,
  parameter int         LOCK_COUNT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  trigger_frame_receiver_if.slave  rx,
  input  logic                     clr_counters,
  output logic                     trigger_out,
  output logic                     frame_valid,
  output logic [7:0]               frame_status,
  output logic [7:0]               frame_ctrl,
  output logic [7:0]               frame_addr0,
  output logic [31:0]              frame_data,
  output logic [15:0]              crc_err_count,
  output logic [15:0]              frame_err_count,
  output logic                     locked
);

  localparam logic [2:0] LOCK_MAX = LOCK_COUNT[2:0];

  typedef enum logic [1:0] {HUNT, PAYLOAD, EOP_WAIT} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  crc;
  logic [7:0]  sh_status;
  logic [7:0]  sh_ctrl;
  logic [7:0]  sh_addr0;
  logic [31:0] sh_data;
  logic [7:0]  sh_crc;
  logic [2:0]  lock_cnt;
  logic [2:0]  lock_next;

  logic clean_sop;
  logic clean_eop;
  logic framing_err;
  logic eop_ok;
  logic good_frame;
  logic crc_fail;

  // CRC8, polynomial 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8_next(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign clean_sop   = rx.rx_is_k && (rx.rx_data == SOP) && !rx.rx_code_err;
  assign clean_eop   = rx.rx_is_k && (rx.rx_data == EOP) && !rx.rx_code_err;
  // Any code error or K byte inside the payload, or anything but a clean EOP after it
  assign framing_err = rx.rx_valid &&
                       (((state == PAYLOAD) && (rx.rx_code_err || rx.rx_is_k)) ||
                        ((state == EOP_WAIT) && !clean_eop));
  assign eop_ok      = rx.rx_valid && (state == EOP_WAIT) && clean_eop;
  assign good_frame  = eop_ok && (crc == sh_crc);
  assign crc_fail    = eop_ok && (crc != sh_crc);

  // Frame delineation FSM with registered frame outputs and result pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HUNT;
      idx          <= 3'd0;
      crc          <= 8'h00;
      sh_status    <= 8'h00;
      sh_ctrl      <= 8'h00;
      sh_addr0     <= 8'h00;
      sh_data      <= 32'h0;
      sh_crc       <= 8'h00;
      trigger_out  <= 1'b0;
      frame_valid  <= 1'b0;
      frame_status <= 8'h00;
      frame_ctrl   <= 8'h00;
      frame_addr0  <= 8'h00;
      frame_data   <= 32'h0;
    end else begin
      trigger_out <= 1'b0;
      frame_valid <= 1'b0;
      if (rx.rx_valid) begin
        if (framing_err) begin
          // A clean SOP that breaks a frame starts the next one directly
          state <= clean_sop ? PAYLOAD : HUNT;
          idx   <= 3'd0;
          crc   <= 8'h00;
        end else begin
          case (state)
            HUNT: begin
              if (clean_sop) begin
                state <= PAYLOAD;
                idx   <= 3'd0;
                crc   <= 8'h00;
              end
            end
            PAYLOAD: begin
              case (idx)
                3'd0:    sh_status <= rx.rx_data;
                3'd1:    sh_ctrl   <= rx.rx_data;
                3'd2:    sh_addr0  <= rx.rx_data;
                3'd7:    sh_crc    <= rx.rx_data;
                default: sh_data   <= {sh_data[23:0], rx.rx_data};
              endcase
              if (idx != 3'd7) begin
                crc <= crc8_next(crc, rx.rx_data);
              end else begin
                state <= EOP_WAIT;
              end
              idx <= idx + 3'd1;
            end
            EOP_WAIT: begin
              // Only a clean EOP reaches here; errors were handled above
              if (crc == sh_crc) begin
                frame_status <= sh_status;
                frame_ctrl   <= sh_ctrl;
                frame_addr0  <= sh_addr0;
                frame_data   <= sh_data;
                frame_valid  <= 1'b1;
                trigger_out  <= |(sh_ctrl & TRIG_MASK);
              end
              state <= HUNT;
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

  // Next lock count: cleared by any error, saturating increment on good frames
  always_comb begin
    lock_next = lock_cnt;
    if (framing_err || crc_fail) begin
      lock_next = 3'd0;
    end else if (good_frame && (lock_cnt != LOCK_MAX)) begin
      lock_next = lock_cnt + 3'd1;
    end
  end

  // Saturating error counters (clear has priority) and lock indication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_err_count   <= 16'h0;
      frame_err_count <= 16'h0;
      lock_cnt        <= 3'd0;
      locked          <= 1'b0;
    end else begin
      if (clr_counters) begin
        crc_err_count   <= 16'h0;
        frame_err_count <= 16'h0;
      end else begin
        if (crc_fail && (crc_err_count != 16'hFFFF)) begin
          crc_err_count <= crc_err_count + 16'd1;
        end
        if (framing_err && (frame_err_count != 16'hFFFF)) begin
          frame_err_count <= frame_err_count + 16'd1;
        end
      end
      lock_cnt <= lock_next;
      locked   <= (lock_next == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_trigger_frame_receiver.sv
// Self-checking bench for trigger_frame_receiver: directed frames from the
// test plan plus randomized frames with injected faults and rx_valid gaps.
// A frame-level reference model pushes expected pulses into a scoreboard queue
// that a separate monitor drains whenever the DUT pulses.
module tb_trigger_frame_receiver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_counters = 1'b0;
  logic        trigger_out;
  logic        frame_valid;
  logic [7:0]  frame_status;
  logic [7:0]  frame_ctrl;
  logic [7:0]  frame_addr0;
  logic [31:0] frame_data;
  logic [15:0] crc_err_count;
  logic [15:0] frame_err_count;
  logic        locked;

  trigger_frame_receiver_if rx_if ();

  trigger_frame_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx_if),
    .clr_counters    (clr_counters),
    .trigger_out     (trigger_out),
    .frame_valid     (frame_valid),
    .frame_status    (frame_status),
    .frame_ctrl      (frame_ctrl),
    .frame_addr0     (frame_addr0),
    .frame_data      (frame_data),
    .crc_err_count   (crc_err_count),
    .frame_err_count (frame_err_count),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  bit gaps_en = 1'b0;

  typedef struct {
    bit          trig;
    logic [7:0]  st;
    logic [7:0]  ct;
    logic [7:0]  a0;
    logic [31:0] dat;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  bit          m_in_frame = 1'b0;
  logic [7:0]  pay_q[$];
  int          m_crc = 0;
  int          m_frm = 0;
  int          m_lock = 0;
  logic [7:0]  m_st = 8'h00;
  logic [7:0]  m_ct = 8'h00;
  logic [7:0]  m_a0 = 8'h00;
  logic [31:0] m_dat = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // CRC as the remainder of message*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_of(input logic [55:0] msg);
    logic [63:0] r;
    r = {msg, 8'h00};
    for (int b = 63; b >= 8; b--) begin
      if (r[b]) r[b -: 9] = r[b -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic model_err(input bit sop_c);
    if (m_frm < 65535) m_frm++;
    m_lock = 0;
    m_in_frame = sop_c;
    pay_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] d, input bit k, input bit e);
    bit sop_c, eop_c;
    exp_t x;
    logic [55:0] msg;
    sop_c = k && (d == 8'h3C) && !e;
    eop_c = k && (d == 8'hBC) && !e;
    if (!m_in_frame) begin
      if (sop_c) begin
        m_in_frame = 1'b1;
        pay_q.delete();
      end
    end else if (pay_q.size() < 8) begin
      if (e || k) model_err(sop_c);
      else pay_q.push_back(d);
    end else if (eop_c) begin
      msg = {pay_q[0], pay_q[1], pay_q[2], pay_q[3], pay_q[4], pay_q[5], pay_q[6]};
      if (crc_of(msg) == pay_q[7]) begin
        m_st  = pay_q[0];
        m_ct  = pay_q[1];
        m_a0  = pay_q[2];
        m_dat = {pay_q[3], pay_q[4], pay_q[5], pay_q[6]};
        x.trig = (pay_q[1] & 8'h08) != 8'h00;
        x.st = m_st; x.ct = m_ct; x.a0 = m_a0; x.dat = m_dat;
        x.cyc = cyc + 1;
        exp_q.push_back(x);
        if (m_lock < 4) m_lock++;
      end else begin
        if (m_crc < 65535) m_crc++;
        m_lock = 0;
      end
      m_in_frame = 1'b0;
      pay_q.delete();
    end else begin
      model_err(sop_c);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      clr_counters = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit k, input bit e = 1'b0, input bit clr = 1'b0);
    int g;
    g = gaps_en ? int'($urandom_range(0, 3)) : 0;
    idle(g);
    @(negedge clk);
    rx_if.rx_valid    = 1'b1;
    rx_if.rx_data     = d;
    rx_if.rx_is_k     = k;
    rx_if.rx_code_err = e;
    clr_counters      = clr;
    model_byte(d, k, e);
    if (clr) begin
      m_crc = 0;
      m_frm = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] st, input logic [7:0] ct, input logic [7:0] a0,
                            input logic [31:0] dat, input bit force_crc = 1'b0,
                            input logic [7:0] crc_val = 8'h00, input bit clr_eop = 1'b0);
    logic [7:0] b[8];
    b[0] = st; b[1] = ct; b[2] = a0;
    b[3] = dat[31:24]; b[4] = dat[23:16]; b[5] = dat[15:8]; b[6] = dat[7:0];
    b[7] = force_crc ? crc_val : crc_of({st, ct, a0, dat});
    send(8'h3C, 1'b1);
    for (int i = 0; i < 8; i++) send(b[i], 1'b0);
    send(8'hBC, 1'b1, 1'b0, clr_eop);
  endtask

  task automatic checkpoint(input string tag);
    idle(3);
    chk({tag, ".crc_err_count"}, 32'(crc_err_count), 32'(m_crc));
    chk({tag, ".frame_err_count"}, 32'(frame_err_count), 32'(m_frm));
    chk({tag, ".locked"}, 32'(locked), 32'(m_lock == 4));
    chk({tag, ".frame_status"}, 32'(frame_status), 32'(m_st));
    chk({tag, ".frame_ctrl"}, 32'(frame_ctrl), 32'(m_ct));
    chk({tag, ".frame_addr0"}, 32'(frame_addr0), 32'(m_a0));
    chk({tag, ".frame_data"}, frame_data, m_dat);
    chk({tag, ".pending_pulses"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_if.rx_valid = 1'b0;
    clr_counters = 1'b0;
    m_in_frame = 1'b0; pay_q.delete();
    m_crc = 0; m_frm = 0; m_lock = 0;
    m_st = 8'h00; m_ct = 8'h00; m_a0 = 8'h00; m_dat = 32'h0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One randomized frame, possibly corrupted, preceded by random idle bytes
  task automatic rand_frame();
    logic [7:0] fd[10];
    bit fk[10], fe[10];
    int kind, n, p;
    logic [7:0] d;
    bit k;
    repeat ($urandom_range(0, 2)) begin
      d = 8'($urandom);
      k = ($urandom_range(0, 3) == 0);
      if (k && d == 8'h3C) d = 8'hBC;
      send(d, k, ($urandom_range(0, 7) == 0));
    end
    fd[0] = 8'h3C; fk[0] = 1'b1;
    for (int i = 1; i < 8; i++) begin fd[i] = 8'($urandom); fk[i] = 1'b0; end
    if ($urandom_range(0, 1) == 0) fd[2] = fd[2] & 8'hF7;
    fd[8] = crc_of({fd[1], fd[2], fd[3], fd[4], fd[5], fd[6], fd[7]}); fk[8] = 1'b0;
    fd[9] = 8'hBC; fk[9] = 1'b1;
    for (int i = 0; i < 10; i++) fe[i] = 1'b0;
    n = 10;
    kind = $urandom_range(0, 5);
    case (kind)
      1: fd[8] = fd[8] ^ (8'h01 << $urandom_range(0, 7));
      2: fe[$urandom_range(0, 9)] = 1'b1;
      3: begin
        p = $urandom_range(1, 8);
        fk[p] = 1'b1;
        case ($urandom_range(0, 2))
          0: fd[p] = 8'h3C;
          1: fd[p] = 8'hBC;
          default: fd[p] = 8'h1C;
        endcase
      end
      4: n = $urandom_range(2, 9);
      5: begin
        fd[9] = 8'($urandom);
        fk[9] = $urandom_range(0, 1) == 1;
        if (fk[9] && fd[9] == 8'hBC) fd[9] = 8'hBD;
      end
      default: ;
    endcase
    for (int i = 0; i < n; i++) send(fd[i], fk[i], fe[i]);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    if (reset && (frame_valid || trigger_out)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: frame_valid=%0b trigger_out=%0b required no pulse (cycle %0d)",
                 frame_valid, trigger_out, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse.frame_valid", 32'(frame_valid), 32'd1);
        chk("pulse.trigger_out", 32'(trigger_out), 32'(e.trig));
        chk("pulse.frame_status", 32'(frame_status), 32'(e.st));
        chk("pulse.frame_ctrl", 32'(frame_ctrl), 32'(e.ct));
        chk("pulse.frame_addr0", 32'(frame_addr0), 32'(e.a0));
        chk("pulse.frame_data", frame_data, e.dat);
      end
    end
  end

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data = 8'h00;
    rx_if.rx_is_k = 1'b0;
    rx_if.rx_code_err = 1'b0;
    do_reset();
    chk("reset.trigger_out", 32'(trigger_out), 32'd0);
    chk("reset.frame_valid", 32'(frame_valid), 32'd0);
    checkpoint("reset");

    // Idle frame then trigger frame with the known CRC 4F
    send_frame(8'h00, 8'h00, 8'h00, 32'h0);
    checkpoint("idle_frame");
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h4F);
    checkpoint("trigger_frame");

    // Corrupted CRC: no pulse, outputs held
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h4E);
    checkpoint("crc_error");

    // Truncated frame resynchronised by a new SOP
    send(8'h3C, 1'b1); send(8'h00, 1'b0); send(8'h08, 1'b0);
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h4F);
    checkpoint("resync");

    // Lock after 4 back-to-back good frames, lost on a code error
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'(i), 8'h08, 8'h5A, 32'hDEADBEEF + i);
    checkpoint("lock_3");
    send_frame(8'h33, 8'h01, 8'hA5, 32'h01234567);
    checkpoint("lock_4");
    send(8'h3C, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0, 1'b1);
    checkpoint("lock_lost");
    @(negedge clk); clr_counters = 1'b1; m_crc = 0; m_frm = 0;
    checkpoint("clr_counters");

    // Clear coinciding with a CRC error increment: clear wins
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h00);
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
    checkpoint("clr_wins");

    // Gapped trigger frame
    gaps_en = 1'b1;
    send_frame(8'hC3, 8'h0F, 8'h7E, 32'hCAFEF00D);
    checkpoint("gapped");

    // Reset mid-frame at idx 4, then a clean frame
    send(8'h3C, 1'b1); send(8'h00, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    do_reset();
    checkpoint("reset_mid_frame");
    send_frame(8'h00, 8'h08, 8'h00, 32'h0, 1'b1, 8'h4F);
    checkpoint("after_reset");

    // Randomized frames with faults and gaps
    for (int i = 0; i < 150; i++) begin
      gaps_en = $urandom_range(0, 1) == 1;
      rand_frame();
      if ((i % 10) == 9) checkpoint("random");
    end
    checkpoint("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
